// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the execution sequencer and the core's control decoder:
// FSM states, run/step mode, halt-cause codes and the jump opcode.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_READY  = 2'd2,
        ST_ISSUE  = 2'd3
    } state_e;

    typedef enum logic {
        MODE_STEP = 1'b0,
        MODE_RUN  = 1'b1
    } mode_e;

    localparam logic [1:0] CAUSE_USER = 2'd0;
    localparam logic [1:0] CAUSE_BP   = 2'd1;
    localparam logic [1:0] CAUSE_LOOP = 2'd2;

    // J-type opcode, also decoded by the core's control unit.
    localparam logic [5:0] OP_JUMP = 6'b000010;

    // A jump whose target is its own address never makes progress.
    function automatic logic is_self_loop(input logic [31:0] inst, input logic [7:0] pc);
        return (inst[31:26] == OP_JUMP) && (inst[7:0] == pc);
    endfunction

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Sequencer <-> datapath bus.
// Handshake: there is no back-pressure. cpu_en is a single-cycle advance
// pulse; the datapath must capture PC/register-file/data-memory writes on
// the clock edge that ends a cycle in which cpu_en is high, and must hold
// pc/inst stable otherwise. halted/halt_cause/instr_count/state are status.
interface cpu_step_ctrl_if;
    import cpu_ctrl_pkg::*;

    logic [7:0]  pc;
    logic [31:0] inst;
    logic        cpu_en;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [15:0] instr_count;
    state_e      state;

    modport master (
        input  pc, inst,
        output cpu_en, halted, halt_cause, instr_count, state
    );

    modport slave (
        output pc, inst,
        input  cpu_en, halted, halt_cause, instr_count, state
    );
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-level debounce counter,
// and a one-cycle pulse on the press (falling edge of the debounced level).
// The key is active-low, so the idle level is 1.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          key_s1;
    logic          key_s2;
    logic          key_level;
    logic [CW-1:0] cnt;

    // Synchronize, then accept a new level only after it has differed from
    // the accepted level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1    <= 1'b1;
            key_s2    <= 1'b1;
            key_level <= 1'b1;
            cnt       <= '0;
            press     <= 1'b0;
        end else begin
            key_s1 <= key_raw;
            key_s2 <= key_s1;
            press  <= 1'b0;
            if (key_s2 != key_level) begin
                if (cnt == CNT_LAST) begin
                    key_level <= key_s2;
                    cnt       <= '0;
                    press     <= ~key_s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/cpu_step_ctrl.sv
// Execution sequencer for the 8-bit single-cycle core. Issues a one-cycle
// cpu_en on the system clock in run or single-step mode, stops on a PC
// breakpoint or a jump-to-self, and keeps a settle window after every
// instruction so the synchronous ROM/RAM outputs are valid before the next.
// RUN_FREQ must leave CLK_FREQ/RUN_FREQ >= SETTLE_CYCLES+2.
module cpu_step_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int RUN_FREQ        = 2,
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic                  clk,
    input  logic                  _rst,
    input  logic                  run_sw,
    input  logic                  step_key,
    input  logic                  bp_en,
    input  logic [7:0]            bp_addr,
    cpu_step_ctrl_if.master       bus
);
    localparam int P  = CLK_FREQ / RUN_FREQ;
    localparam int TW = (P > 1) ? $clog2(P) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST   = TW'(P - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    logic          run_s1;
    logic          run_s2;
    logic          run_s3;
    logic          run_rise;
    logic          step_press;

    state_e        state;
    mode_e         mode;
    logic [TW-1:0] tick_cnt;
    logic          tick_pending;
    logic          bp_skip;
    logic [SW-1:0] settle_cnt;
    logic          cpu_en_r;
    logic          halted_r;
    logic [1:0]    halt_cause_r;
    logic [15:0]   instr_count_r;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_key (
        .clk     (clk),
        .rst_n   (_rst),
        .key_raw (step_key),
        .press   (step_press)
    );

    // Synchronize the run switch and register its 0->1 edge as a pulse.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            run_s1   <= 1'b0;
            run_s2   <= 1'b0;
            run_s3   <= 1'b0;
            run_rise <= 1'b0;
        end else begin
            run_s1   <= run_sw;
            run_s2   <= run_s1;
            run_s3   <= run_s2;
            run_rise <= run_s2 & ~run_s3;
        end
    end

    // Sequencer FSM with the run-rate tick counter; all outputs registered.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state         <= ST_HALT;
            mode          <= MODE_STEP;
            tick_cnt      <= '0;
            tick_pending  <= 1'b0;
            bp_skip       <= 1'b0;
            settle_cnt    <= '0;
            cpu_en_r      <= 1'b0;
            halted_r      <= 1'b1;
            halt_cause_r  <= CAUSE_USER;
            instr_count_r <= '0;
        end else begin
            cpu_en_r <= 1'b0;

            // Free-running rate tick while running; ticks that land in
            // SETTLE stay pending, and several ticks collapse into one.
            if (mode == MODE_RUN && state != ST_HALT) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt     <= '0;
                    tick_pending <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end

            case (state)
                ST_HALT: begin
                    // Run beats a simultaneous step; the step is dropped.
                    if (run_rise) begin
                        state        <= ST_SETTLE;
                        mode         <= MODE_RUN;
                        tick_cnt     <= '0;
                        tick_pending <= 1'b0;
                        bp_skip      <= 1'b1;
                        settle_cnt   <= '0;
                        halted_r     <= 1'b0;
                    end else if (step_press) begin
                        state    <= ST_ISSUE;
                        mode     <= MODE_STEP;
                        bp_skip  <= 1'b1;
                        cpu_en_r <= 1'b1;
                        halted_r <= 1'b0;
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_READY;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                ST_READY: begin
                    if (mode == MODE_STEP) begin
                        state    <= ST_HALT;
                        halted_r <= 1'b1;
                    end else if (!run_s2) begin
                        state        <= ST_HALT;
                        halted_r     <= 1'b1;
                        halt_cause_r <= CAUSE_USER;
                    end else if (bp_en && bus.pc == bp_addr && !bp_skip) begin
                        state        <= ST_HALT;
                        halted_r     <= 1'b1;
                        halt_cause_r <= CAUSE_BP;
                    end else if (is_self_loop(bus.inst, bus.pc)) begin
                        state        <= ST_HALT;
                        halted_r     <= 1'b1;
                        halt_cause_r <= CAUSE_LOOP;
                    end else if (tick_pending) begin
                        state        <= ST_ISSUE;
                        tick_pending <= 1'b0;
                        cpu_en_r     <= 1'b1;
                    end
                end

                ST_ISSUE: begin
                    // Count on leaving ISSUE so a reset inside it never counts.
                    instr_count_r <= instr_count_r + 16'd1;
                    bp_skip       <= 1'b0;
                    settle_cnt    <= '0;
                    state         <= ST_SETTLE;
                end

                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

    assign bus.cpu_en      = cpu_en_r;
    assign bus.halted      = halted_r;
    assign bus.halt_cause  = halt_cause_r;
    assign bus.instr_count = instr_count_r;
    assign bus.state       = state;

endmodule
